// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared RISC-V pipeline definitions: hazard FSM states and architectural constants.
package pipe_hazard_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    MEM_WAIT      = 2'd1,
    MEM_WAIT_PEND = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, pipeline steering and counters out.
// Every signal is a level, sampled once per cycle; there is no handshake, each cycle's
// outputs are a pure function of that cycle's inputs and the controller state.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [4:0]      ex_rd;
  logic            ex_memread;
  logic            ex_branch_taken;
  logic [XLEN-1:0] ex_target;
  logic            im_wait;
  logic            dm_wait;

  logic            pc_write;
  logic            ifid_write;
  logic            ifid_flush;
  logic            idex_flush;
  logic            pipe_hold;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] stall_cnt;
  logic [XLEN-1:0] flush_cnt;
  hz_state_e       state_dbg;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, ex_target, im_wait, dm_wait,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold,
           redirect_valid, redirect_target, stall_cnt, flush_cnt, state_dbg
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
           ex_branch_taken, ex_target, im_wait, dm_wait,
    output pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold,
           redirect_valid, redirect_target, stall_cnt, flush_cnt, state_dbg
  );
endinterface

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// 32-bit event counter with synchronous clear and optional saturation at all-ones.
module perf_counter
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            inc,
  input  logic            sat_en,
  output logic [XLEN-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && !(sat_en && (cnt == '1))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, load-use stall and branch redirect,
// with a branch resolved during a freeze held pending until the memories are ready.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  hz_state_e       state, state_nxt;
  logic [XLEN-1:0] pend, pend_nxt;
  logic            mw, lu;
  logic            pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, redirect_valid;
  logic [XLEN-1:0] redirect_target;

  assign mw = hz.im_wait | hz.dm_wait;
  assign lu = hz.ex_memread && (hz.ex_rd != ZERO_REG) &&
              ((hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
               (hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pend_nxt        = pend;
    pc_write        = 1'b0;
    ifid_write      = 1'b0;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    pipe_hold       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    if (rst) begin
      state_nxt = RUN;
      pend_nxt  = '0;
    end else if (mw) begin
      pipe_hold = 1'b1;
      // Once a redirect is pending, later branch reports belong to squashed instructions.
      if (state != MEM_WAIT_PEND) begin
        if (hz.ex_branch_taken) begin
          state_nxt = MEM_WAIT_PEND;
          pend_nxt  = hz.ex_target;
        end else begin
          state_nxt = MEM_WAIT;
        end
      end
    end else if (state == MEM_WAIT_PEND) begin
      redirect_valid  = 1'b1;
      redirect_target = pend;
      pc_write        = 1'b1;
      ifid_write      = 1'b1;
      ifid_flush      = 1'b1;
      idex_flush      = 1'b1;
      state_nxt       = RUN;
    end else begin
      state_nxt = RUN;
      if (hz.ex_branch_taken) begin
        redirect_valid  = 1'b1;
        redirect_target = hz.ex_target;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ifid_flush      = 1'b1;
        idex_flush      = 1'b1;
      end else if (lu) begin
        idex_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  assign hz.pc_write        = pc_write;
  assign hz.ifid_write      = ifid_write;
  assign hz.ifid_flush      = ifid_flush;
  assign hz.idex_flush      = idex_flush;
  assign hz.pipe_hold       = pipe_hold;
  assign hz.redirect_valid  = redirect_valid;
  assign hz.redirect_target = redirect_target;
  assign hz.state_dbg       = state;

  perf_counter u_stall_cnt (
    .clk    (clk),
    .clr    (rst),
    .inc    (mw),
    .sat_en (1'b1),
    .cnt    (hz.stall_cnt)
  );

  perf_counter u_flush_cnt (
    .clk    (clk),
    .clr    (rst),
    .inc    (redirect_valid),
    .sat_en (1'b0),
    .cnt    (hz.flush_cnt)
  );

endmodule
